sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO for fabric-side buffering between Wishbone/PIO logic and any consumer that shares one clock. It generalises the fixed 512x16 dual-clock FIFO wrapper: width and depth are parameters, almost-full/almost-empty thresholds are programmable, a first-word-fall-through (FWFT) read mode is selectable, and there is an occupancy count plus sticky overflow/underflow error flags. Storage is a simple-dual-port RAM array with registered read, so it maps to a block RAM.

---
 rtl/sync_fifo_flags.sv | 110 +++++++++++
 tb/tb_sync_fifo_flags.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO over a registered-read RAM: programmable almost-full/empty, optional FWFT head register, sticky error flags.
// Read data one edge after POP (FWFT: head shows two edges after a push into empty); a rejected PUSH/POP is dropped and latched in Overflow/Underflow.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_LEVEL   = 508,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Flush,
  input  logic                  PUSH,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  POP,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [ADDR_WIDTH:0]   Level,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam logic [ADDR_WIDTH:0] LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LVL_AF   = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LVL_AE   = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam bit                  IS_FWFT  = (FWFT != 0);

  logic [DATA_WIDTH-1:0] ram [0:(1 << ADDR_WIDTH)-1];

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  head_vld;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  ram_has_data;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  rd_adv;

  assign ram_has_data = (wr_ptr != rd_ptr);

  // rd_adv moves a word out of RAM into DOUT; in FWFT mode it also refills an empty or consumed head.
  always_comb begin
    pop_acc  = 1'b0;
    push_acc = 1'b0;
    rd_adv   = 1'b0;
    if (!Rst && !Flush) begin
      pop_acc  = POP && (IS_FWFT ? head_vld : ram_has_data);
      push_acc = PUSH && ((level != LVL_FULL) || pop_acc);
      rd_adv   = IS_FWFT ? ((!head_vld || pop_acc) && ram_has_data) : pop_acc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dout_q   <= '0;
      head_vld <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (Flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      head_vld <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout_q <= ram[rd_ptr[ADDR_WIDTH-1:0]];
      end
      head_vld <= IS_FWFT && (rd_adv || (head_vld && !pop_acc));
      if (push_acc && !pop_acc)
        level <= level + PTR_ONE;
      else if (pop_acc && !push_acc)
        level <= level - PTR_ONE;
      if (PUSH && !push_acc)
        ovf_q <= 1'b1;
      if (POP && !pop_acc)
        udf_q <= 1'b1;
    end
  end

  // Read-first: when full, a same-cycle push overwrites the slot being read, and DOUT gets the old word.
  always_ff @(posedge Clk) begin
    if (push_acc)
      ram[wr_ptr[ADDR_WIDTH-1:0]] <= DIN;
  end

  assign DOUT         = dout_q;
  assign Full         = (level == LVL_FULL);
  assign Empty        = IS_FWFT ? !head_vld : !ram_has_data;
  assign Almost_Full  = (level >= LVL_AF);
  assign Almost_Empty = (level <= LVL_AE);
  assign Level        = level;
  assign Overflow     = ovf_q;
  assign Underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a registered-read and an FWFT instance share stimulus, each checked against a queue model.
module tb_sync_fifo_flags;
  localparam int DEPTH = 512;

  typedef struct {
    logic [15:0] d;
    int unsigned st;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0, Flush = 1'b0, PUSH = 1'b0, POP = 1'b0;
  logic [15:0] DIN = '0;

  logic [15:0] dout0, dout1;
  logic        full0, empty0, af0, ae0, ovf0, udf0;
  logic        full1, empty1, af1, ae1, ovf1, udf1;
  logic [9:0]  level0, level1;

  wire [15:0] obs0 = {full0, empty0, af0, ae0, level0, ovf0, udf0};
  wire [15:0] obs1 = {full1, empty1, af1, ae1, level1, ovf1, udf1};

  sync_fifo_flags #(.FWFT(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .PUSH(PUSH), .DIN(DIN), .POP(POP),
    .DOUT(dout0), .Full(full0), .Empty(empty0), .Almost_Full(af0),
    .Almost_Empty(ae0), .Level(level0), .Overflow(ovf0), .Underflow(udf0));

  sync_fifo_flags #(.FWFT(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .PUSH(PUSH), .DIN(DIN), .POP(POP),
    .DOUT(dout1), .Full(full1), .Empty(empty1), .Almost_Full(af1),
    .Almost_Empty(ae1), .Level(level1), .Overflow(ovf1), .Underflow(udf1));

  always #5 Clk = ~Clk;

  // Reference state: plain queues of stored words; the FWFT head becomes visible only
  // once it was written at an earlier edge than the one that exposes it.
  logic [15:0] q0[$];
  ent_t        q1[$];
  logic [15:0] md0 = '0, md1 = '0;
  bit          mvis1, movf0, mudf0, movf1, mudf1;
  int unsigned t = 0;
  int          errors = 0, checks = 0;

  localparam logic [15:0] RESET_FLAGS = {1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0};

  function automatic logic [15:0] exp_flags(input int sz, input bit emp, input bit ovf, input bit udf);
    return {sz == DEPTH, emp, sz >= 508, sz <= 4, 10'(sz), ovf, udf};
  endfunction

  task automatic step(input bit rs, input bit fl, input bit pu, input logic [15:0] d, input bit po);
    bit pa, wa;
    Rst = rs; Flush = fl; PUSH = pu; DIN = d; POP = po;
    @(posedge Clk);
    t++;
    if (rs || fl) begin
      q0.delete(); q1.delete();
      mvis1 = 0; movf0 = 0; mudf0 = 0; movf1 = 0; mudf1 = 0;
      if (rs) begin md0 = '0; md1 = '0; end
    end else begin
      pa = po && (q0.size() != 0);
      wa = pu && ((q0.size() < DEPTH) || pa);
      if (po && !pa) mudf0 = 1;
      if (pu && !wa) movf0 = 1;
      if (pa) md0 = q0.pop_front();
      if (wa) q0.push_back(d);

      pa = po && mvis1;
      wa = pu && ((q1.size() < DEPTH) || pa);
      if (po && !pa) mudf1 = 1;
      if (pu && !wa) movf1 = 1;
      if (pa) void'(q1.pop_front());
      if (wa) q1.push_back('{d, t});
      if (!mvis1 || pa) begin
        mvis1 = (q1.size() != 0) && (q1[0].st < t);
        if (mvis1) md1 = q1[0].d;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 16'h0, 0);
    checks++;
    if (obs0 !== RESET_FLAGS) begin errors++; $display("FAIL reset_flags0 got=%h exp=%h", obs0, RESET_FLAGS); end
    checks++;
    if (obs1 !== RESET_FLAGS) begin errors++; $display("FAIL reset_flags1 got=%h exp=%h", obs1, RESET_FLAGS); end
    checks++;
    if ({dout0, dout1} !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h/%h exp=0/0", dout0, dout1); end
    step(0, 0, 0, 16'h0, 0);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 1, 16'(i), 0);
      checks++;
      if (obs0 !== exp_flags(q0.size(), q0.size() == 0, movf0, mudf0)) begin
        errors++; $display("FAIL fill_flags0 i=%0d got=%h exp=%h", i, obs0, exp_flags(q0.size(), q0.size() == 0, movf0, mudf0));
      end
      checks++;
      if (obs1 !== exp_flags(q1.size(), !mvis1, movf1, mudf1)) begin
        errors++; $display("FAIL fill_flags1 i=%0d got=%h exp=%h", i, obs1, exp_flags(q1.size(), !mvis1, movf1, mudf1));
      end
    end
    checks++;
    if ({full0, af0, level0} !== {1'b1, 1'b1, 10'd512}) begin
      errors++; $display("FAIL fill_full got full=%b af=%b level=%0d exp 1 1 512", full0, af0, level0);
    end
    step(0, 0, 1, 16'h0201, 0);
    checks++;
    if ({ovf0, level0} !== {1'b1, 10'd512}) begin
      errors++; $display("FAIL fill_overflow got ovf=%b level=%0d exp 1 512", ovf0, level0);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 1024; i++) begin
      step(0, 0, 1, 16'(513 + i), 1);
      checks++;
      if ({level0, dout0} !== {10'd512, 16'(i + 1)}) begin
        errors++; $display("FAIL stream0 i=%0d got level=%0d dout=%h exp 512 %h", i, level0, dout0, 16'(i + 1));
      end
      checks++;
      if (obs1 !== exp_flags(q1.size(), !mvis1, movf1, mudf1) || (mvis1 && dout1 !== md1)) begin
        errors++; $display("FAIL stream1 i=%0d got=%h/%h exp=%h/%h", i, obs1, dout1, exp_flags(q1.size(), !mvis1, movf1, mudf1), md1);
      end
    end
  endtask

  task automatic test_flush();
    step(0, 1, 0, 16'h0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 16'($urandom), 0);
    checks++;
    if (level0 !== 10'd100) begin errors++; $display("FAIL flush_pre got level=%0d exp 100", level0); end
    step(0, 1, 1, 16'h1234, 1);
    checks++;
    if ({level0, empty0, ae0, ovf0, udf0} !== {10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush0 got level=%0d e=%b ae=%b ovf=%b udf=%b exp 0 1 1 0 0", level0, empty0, ae0, ovf0, udf0);
    end
    checks++;
    if ({level1, empty1, ae1, ovf1, udf1} !== {10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush1 got level=%0d e=%b ae=%b ovf=%b udf=%b exp 0 1 1 0 0", level1, empty1, ae1, ovf1, udf1);
    end
    step(0, 0, 1, 16'hC3C3, 0);
    step(0, 0, 0, 16'h0, 1);
    checks++;
    if ({dout0, dout1, empty1} !== {16'hC3C3, 16'hC3C3, 1'b0}) begin
      errors++; $display("FAIL flush_readback got %h/%h empty1=%b exp c3c3/c3c3 0", dout0, dout1, empty1);
    end
  endtask

  task automatic test_same_cycle();
    step(0, 1, 0, 16'h0, 0);
    step(0, 0, 1, 16'hBEEF, 1);
    checks++;
    if ({udf0, level0, udf1, level1} !== {1'b1, 10'd1, 1'b1, 10'd1}) begin
      errors++; $display("FAIL same_cycle got udf=%b/%b level=%0d/%0d exp 1/1 1/1", udf0, udf1, level0, level1);
    end
    step(0, 0, 0, 16'h0, 1);
    checks++;
    if ({dout0, level0} !== {16'hBEEF, 10'd0}) begin
      errors++; $display("FAIL same_cycle_pop0 got dout=%h level=%0d exp beef 0", dout0, level0);
    end
    checks++;
    if (obs1 !== exp_flags(q1.size(), !mvis1, movf1, mudf1) || dout1 !== 16'hBEEF) begin
      errors++; $display("FAIL same_cycle_pop1 got=%h/%h exp=%h/beef", obs1, dout1, exp_flags(q1.size(), !mvis1, movf1, mudf1));
    end
  endtask

  task automatic test_fwft();
    step(0, 1, 0, 16'h0, 0);
    step(0, 0, 1, 16'hA5A5, 0);
    checks++;
    if ({empty1, level1} !== {1'b1, 10'd1}) begin
      errors++; $display("FAIL fwft_n1 got empty=%b level=%0d exp 1 1", empty1, level1);
    end
    step(0, 0, 0, 16'h0, 0);
    checks++;
    if ({empty1, dout1} !== {1'b0, 16'hA5A5}) begin
      errors++; $display("FAIL fwft_n2 got empty=%b dout=%h exp 0 a5a5", empty1, dout1);
    end
    step(0, 0, 0, 16'h0, 1);
    checks++;
    if ({empty1, level1, udf1} !== {1'b1, 10'd0, 1'b0}) begin
      errors++; $display("FAIL fwft_pop got empty=%b level=%0d udf=%b exp 1 0 0", empty1, level1, udf1);
    end
  endtask

  task automatic test_rst_mid();
    step(0, 1, 0, 16'h0, 0);
    for (int i = 0; i <= DEPTH; i++) step(0, 0, 1, 16'($urandom), 0);
    for (int i = 0; i < DEPTH - 37; i++) step(0, 0, 0, 16'h0, 1);
    checks++;
    if ({level0, ovf0} !== {10'd37, 1'b1}) begin
      errors++; $display("FAIL rst_mid_pre got level=%0d ovf=%b exp 37 1", level0, ovf0);
    end
    step(1, 0, 1, 16'h7777, 1);
    checks++;
    if (obs0 !== RESET_FLAGS || dout0 !== 16'h0) begin
      errors++; $display("FAIL rst_mid0 got=%h dout=%h exp=%h 0", obs0, dout0, RESET_FLAGS);
    end
    checks++;
    if (obs1 !== RESET_FLAGS || dout1 !== 16'h0) begin
      errors++; $display("FAIL rst_mid1 got=%h dout=%h exp=%h 0", obs1, dout1, RESET_FLAGS);
    end
  endtask

  task automatic test_random();
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 700; i++) begin
        bit pu, po, fl;
        pu = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 90 : 15));
        po = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 15 : 90));
        fl = ($urandom_range(0, 299) == 0);
        step(0, fl, pu, 16'($urandom), po);
        checks++;
        if (obs0 !== exp_flags(q0.size(), q0.size() == 0, movf0, mudf0) || dout0 !== md0) begin
          errors++; $display("FAIL random0 ph=%0d i=%0d got=%h/%h exp=%h/%h", ph, i, obs0, dout0, exp_flags(q0.size(), q0.size() == 0, movf0, mudf0), md0);
        end
        checks++;
        if (obs1 !== exp_flags(q1.size(), !mvis1, movf1, mudf1) || (mvis1 && dout1 !== md1)) begin
          errors++; $display("FAIL random1 ph=%0d i=%0d got=%h/%h exp=%h/%h", ph, i, obs1, dout1, exp_flags(q1.size(), !mvis1, movf1, mudf1), md1);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_same_cycle();
    test_fwft();
    test_rst_mid();
    step(0, 0, 0, 16'h0, 0);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
